// File: rtl/segment_ram_arbiter.sv
// Segment status RAM (1 bit per segment) shared between fixed-latency video
// lookups, a clear sequencer and req/ack CPU writes; one RAM access per cycle.
module segment_ram_arbiter #(
  parameter int SEGMENT_COUNT = 1024,
  parameter int ID_WIDTH      = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                vid_req,
  input  logic [ID_WIDTH-1:0] vid_id,
  output logic                vid_valid,
  output logic                vid_value,
  input  logic                cpu_req,
  input  logic [ID_WIDTH-1:0] cpu_id,
  input  logic                cpu_value,
  output logic                cpu_ack,
  input  logic                clear_start,
  output logic                clear_busy
);

  localparam logic [ID_WIDTH:0]   SEG_CNT   = (ID_WIDTH+1)'(SEGMENT_COUNT);
  localparam logic [ID_WIDTH-1:0] LAST_ADDR = ID_WIDTH'(SEGMENT_COUNT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] clear_addr_q, clear_addr_d;
  logic                cpu_ack_q, cpu_ack_d;
  logic                vid_valid_q;
  logic                vid_value_q;

  logic                mem_q [SEGMENT_COUNT];

  logic                ram_we;
  logic [ID_WIDTH-1:0] ram_addr;
  logic                ram_wdata;
  logic                vid_in_range;
  logic                cpu_in_range;

  assign vid_in_range = ({1'b0, vid_id} < SEG_CNT);
  assign cpu_in_range = ({1'b0, cpu_id} < SEG_CNT);

  // Video owns the RAM port whenever it asks; clear and CPU only write in
  // cycles without vid_req. The ack cycle blocks a re-grant of a held request.
  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    cpu_ack_d    = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = clear_addr_q;
    ram_wdata    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_start) begin
          state_d      = ST_CLEAR;
          clear_addr_d = '0;
        end
        if (cpu_req && !vid_req && !cpu_ack_q) begin
          cpu_ack_d = 1'b1;
          if (cpu_in_range) begin
            ram_we    = 1'b1;
            ram_addr  = cpu_id;
            ram_wdata = cpu_value;
          end
        end
      end
      ST_CLEAR: begin
        if (clear_start) begin
          clear_addr_d = '0;
        end else if (!vid_req) begin
          ram_we = 1'b1;
          if (clear_addr_q == LAST_ADDR) begin
            state_d = ST_IDLE;
          end else begin
            clear_addr_d = clear_addr_q + 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clear_addr_q <= '0;
      cpu_ack_q    <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_value_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      cpu_ack_q    <= cpu_ack_d;
      vid_valid_q  <= vid_req;
      if (vid_req) begin
        vid_value_q <= vid_in_range ? mem_q[vid_id] : 1'b0;
      end
    end
  end

  // A grant in the reset cycle is dropped without touching the RAM.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      mem_q[ram_addr] <= ram_wdata;
    end
  end

  assign vid_valid  = vid_valid_q;
  assign vid_value  = vid_value_q;
  assign cpu_ack    = cpu_ack_q;
  assign clear_busy = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_segment_ram_arbiter.sv
// Self-checking bench for segment_ram_arbiter: directed scenarios plus a
// randomized read/write mix against an array-based reference model.
module tb_segment_ram_arbiter;

  localparam int N  = 1024;
  localparam int N2 = 600;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       vid_req = 1'b0;
  logic [9:0] vid_id = '0;
  logic       vid_valid, vid_value;
  logic       cpu_req = 1'b0;
  logic [9:0] cpu_id = '0;
  logic       cpu_value = 1'b0;
  logic       cpu_ack;
  logic       clear_start = 1'b0;
  logic       clear_busy;

  logic       b_vid_req = 1'b0;
  logic [9:0] b_vid_id = '0;
  logic       b_vid_valid, b_vid_value;
  logic       b_cpu_req = 1'b0;
  logic [9:0] b_cpu_id = '0;
  logic       b_cpu_value = 1'b0;
  logic       b_cpu_ack;
  logic       b_clear_busy;

  int checks = 0;
  int errors = 0;
  bit model [N];

  segment_ram_arbiter #(.SEGMENT_COUNT(N), .ID_WIDTH(10)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_id(vid_id), .vid_valid(vid_valid), .vid_value(vid_value),
    .cpu_req(cpu_req), .cpu_id(cpu_id), .cpu_value(cpu_value), .cpu_ack(cpu_ack),
    .clear_start(clear_start), .clear_busy(clear_busy)
  );

  segment_ram_arbiter #(.SEGMENT_COUNT(N2), .ID_WIDTH(10)) dut_small (
    .clk(clk), .reset(reset),
    .vid_req(b_vid_req), .vid_id(b_vid_id), .vid_valid(b_vid_valid), .vid_value(b_vid_value),
    .cpu_req(b_cpu_req), .cpu_id(b_cpu_id), .cpu_value(b_cpu_value), .cpu_ack(b_cpu_ack),
    .clear_start(1'b0), .clear_busy(b_clear_busy)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    int cnt;
    int guard;
    cpu_req = 1'b1; cpu_id = 10'd9; cpu_value = 1'b1;
    reset = 1'b1;
    repeat (3) begin
      tick;
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", cpu_ack); end
    end
    cpu_req = 1'b0;
    reset = 1'b0;
    checks++;
    if ({clear_busy, cpu_ack, vid_valid, vid_value} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_outputs: busy/ack/valid/value got %b want 1000",
               {clear_busy, cpu_ack, vid_valid, vid_value});
    end
    repeat (200) tick;
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL midclear_busy: got %b want 1", clear_busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    cnt = (clear_busy === 1'b1) ? 1 : 0;
    guard = 0;
    while (clear_busy === 1'b1 && guard < 3000) begin
      tick;
      guard++;
      if (clear_busy === 1'b1) cnt++;
    end
    checks++;
    if (cnt != N) begin errors++; $display("FAIL reset_clear_len: got %0d want %0d", cnt, N); end
    foreach (model[i]) model[i] = 1'b0;
  endtask

  task automatic test_video_read;
    int ids [8];
    ids[0] = 0; ids[1] = 511; ids[2] = 1023;
    for (int i = 3; i < 8; i++) ids[i] = int'($urandom_range(0, N - 1));
    for (int i = 0; i < 8; i++) begin
      vid_req = 1'b1; vid_id = 10'(ids[i]);
      tick;
      vid_req = 1'b0;
      checks++;
      if (vid_valid !== 1'b1 || vid_value !== model[ids[i]]) begin
        errors++;
        $display("FAIL vid_read id=%0d: valid/value got %b%b want 1%b", ids[i], vid_valid, vid_value, model[ids[i]]);
      end
    end
    tick;
    checks++;
    if (vid_valid !== 1'b0) begin errors++; $display("FAIL vid_valid_drop: got %b want 0", vid_valid); end
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_id = 10'd37; cpu_value = 1'b1;
    tick;
    model[37] = 1'b1;
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL cpu_ack_37: got %b want 1", cpu_ack); end
    cpu_req = 1'b0;
    vid_req = 1'b1; vid_id = 10'd37;
    tick;
    checks++;
    if (vid_value !== 1'b1 || cpu_ack !== 1'b0) begin
      errors++; $display("FAIL read_37: value/ack got %b%b want 10", vid_value, cpu_ack);
    end
    vid_id = 10'd38;
    tick;
    vid_req = 1'b0;
    checks++;
    if (vid_value !== model[38]) begin errors++; $display("FAIL read_38: got %b want %b", vid_value, model[38]); end
  endtask

  task automatic test_collision;
    cpu_req = 1'b1; cpu_id = 10'd5; cpu_value = 1'b1;
    vid_req = 1'b1; vid_id = 10'd5;
    tick;
    vid_req = 1'b0;
    checks++;
    if (vid_valid !== 1'b1 || vid_value !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL collision_read: valid/value/ack got %b%b%b want 100", vid_valid, vid_value, cpu_ack);
    end
    tick;
    model[5] = 1'b1;
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL collision_ack: got %b want 1", cpu_ack); end
    cpu_req = 1'b0;
    vid_req = 1'b1;
    tick;
    vid_req = 1'b0;
    checks++;
    if (vid_value !== 1'b1) begin errors++; $display("FAIL collision_after: got %b want 1", vid_value); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] acks;
    int ida;
    int idb;
    ida = int'($urandom_range(100, 499));
    idb = int'($urandom_range(500, 999));
    cpu_req = 1'b1; cpu_id = 10'(ida); cpu_value = 1'b1;
    tick; acks[2] = cpu_ack;
    tick; acks[1] = cpu_ack;
    cpu_id = 10'(idb); cpu_value = 1'b1;
    tick; acks[0] = cpu_ack;
    cpu_req = 1'b0;
    model[ida] = 1'b1; model[idb] = 1'b1;
    checks++;
    if (acks !== 3'b101) begin errors++; $display("FAIL b2b_ack_pattern: got %b want 101", acks); end
    tick;
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL b2b_no_extra_ack: got %b want 0", cpu_ack); end
    vid_req = 1'b1; vid_id = 10'(idb);
    tick;
    vid_req = 1'b0;
    checks++;
    if (vid_value !== 1'b1) begin errors++; $display("FAIL b2b_read id=%0d: got %b want 1", idb, vid_value); end
  endtask

  task automatic test_random;
    bit pending = 1'b0;
    bit ack_now = 1'b0;
    bit release_next = 1'b0;
    bit grant;
    bit exp_val = vid_value;
    for (int k = 0; k < 400; k++) begin
      if (ack_now) begin
        if ($urandom_range(0, 1) == 1) release_next = 1'b1;
        else cpu_req = 1'b0;
      end else if (release_next) begin
        cpu_req = 1'b0;
        release_next = 1'b0;
      end
      if (!ack_now && !cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1'b1;
        cpu_id = 10'($urandom_range(0, 63));
        cpu_value = 1'($urandom_range(0, 1));
        pending = 1'b1;
      end
      vid_req = 1'($urandom_range(0, 1));
      vid_id = 10'($urandom_range(0, 63));
      if (vid_req) exp_val = model[vid_id];
      grant = pending && !vid_req;
      if (grant) begin
        model[cpu_id] = cpu_value;
        pending = 1'b0;
      end
      tick;
      checks++;
      if (vid_valid !== vid_req || vid_value !== exp_val || cpu_ack !== grant) begin
        errors++;
        $display("FAIL random cyc=%0d: valid/value/ack got %b%b%b want %b%b%b",
                 k, vid_valid, vid_value, cpu_ack, vid_req, exp_val, grant);
      end
      ack_now = grant;
    end
    vid_req = 1'b0;
    cpu_req = 1'b0;
    if (pending || ack_now) repeat (2) tick;
    if (pending) model[cpu_id] = cpu_value;
    tick;
  endtask

  task automatic test_clear_with_video;
    int cnt;
    int vcount = 0;
    int cp = 0;
    int i = 0;
    bit exp_val;
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    cnt = (clear_busy === 1'b1) ? 1 : 0;
    while (clear_busy === 1'b1 && i < 3000) begin
      vid_req = (i % 4 == 0);
      vid_id = 10'($urandom_range(0, N - 1));
      if (vid_req) begin
        exp_val = model[vid_id];
        vcount++;
      end else if (cp < N) begin
        model[cp] = 1'b0;
        cp++;
      end
      tick;
      if (vid_req) begin
        checks++;
        if (vid_valid !== 1'b1 || vid_value !== exp_val) begin
          errors++;
          $display("FAIL clear_vid i=%0d: valid/value got %b%b want 1%b", i, vid_valid, vid_value, exp_val);
        end
      end
      if (clear_busy === 1'b1) cnt++;
      i++;
    end
    vid_req = 1'b0;
    checks++;
    if (cnt != N + vcount) begin
      errors++; $display("FAIL clear_video_len: got %0d want %0d", cnt, N + vcount);
    end
  endtask

  task automatic test_restart;
    int cnt;
    int guard = 0;
    int id;
    id = int'($urandom_range(0, N - 1));
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    for (int j = 0; j < 300; j++) begin
      if (j == 100) begin
        cpu_req = 1'b1; cpu_id = 10'(id); cpu_value = 1'b1;
      end
      tick;
      if (cpu_ack === 1'b1 || clear_busy !== 1'b1) begin
        checks++; errors++;
        $display("FAIL restart_early j=%0d: ack/busy got %b%b want 01", j, cpu_ack, clear_busy);
      end
    end
    checks++;
    if (clear_busy !== 1'b1) begin errors++; $display("FAIL restart_busy300: got %b want 1", clear_busy); end
    clear_start = 1'b1;
    tick;
    clear_start = 1'b0;
    cnt = (clear_busy === 1'b1) ? 1 : 0;
    while (clear_busy === 1'b1 && guard < 3000) begin
      tick;
      guard++;
      if (clear_busy === 1'b1) begin
        cnt++;
        if (cpu_ack !== 1'b0) begin
          checks++; errors++;
          $display("FAIL restart_ack_busy: got %b want 0", cpu_ack);
        end
      end
    end
    checks++;
    if (cnt != N) begin errors++; $display("FAIL restart_len: got %0d want %0d", cnt, N); end
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL restart_ack_idle: got %b want 0", cpu_ack); end
    tick;
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL restart_ack_after: got %b want 1", cpu_ack); end
    cpu_req = 1'b0;
    foreach (model[i]) model[i] = 1'b0;
    model[id] = 1'b1;
    vid_req = 1'b1; vid_id = 10'(id);
    tick;
    vid_id = 10'((id + 1) % N);
    checks++;
    if (vid_value !== 1'b1) begin errors++; $display("FAIL restart_read id=%0d: got %b want 1", id, vid_value); end
    tick;
    vid_req = 1'b0;
    checks++;
    if (vid_value !== 1'b0) begin errors++; $display("FAIL restart_neighbour: got %b want 0", vid_value); end
  endtask

  task automatic test_out_of_range;
    int wr_ids [2];
    int rd_ids [4];
    bit rd_exp [4];
    wr_ids[0] = 700; wr_ids[1] = 599;
    rd_ids[0] = 700; rd_ids[1] = 188; rd_ids[2] = 599; rd_ids[3] = 600;
    rd_exp[0] = 1'b0; rd_exp[1] = 1'b0; rd_exp[2] = 1'b1; rd_exp[3] = 1'b0;
    checks++;
    if (b_clear_busy !== 1'b0) begin errors++; $display("FAIL oor_busy: got %b want 0", b_clear_busy); end
    for (int i = 0; i < 2; i++) begin
      b_cpu_req = 1'b1; b_cpu_id = 10'(wr_ids[i]); b_cpu_value = 1'b1;
      tick;
      b_cpu_req = 1'b0;
      checks++;
      if (b_cpu_ack !== 1'b1) begin errors++; $display("FAIL oor_ack id=%0d: got %b want 1", wr_ids[i], b_cpu_ack); end
      tick;
    end
    for (int i = 0; i < 4; i++) begin
      b_vid_req = 1'b1; b_vid_id = 10'(rd_ids[i]);
      tick;
      b_vid_req = 1'b0;
      checks++;
      if (b_vid_valid !== 1'b1 || b_vid_value !== rd_exp[i]) begin
        errors++;
        $display("FAIL oor_read id=%0d: valid/value got %b%b want 1%b", rd_ids[i], b_vid_valid, b_vid_value, rd_exp[i]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_video_read;
    test_cpu_write;
    test_collision;
    test_back_to_back;
    test_random;
    test_video_read;
    test_clear_with_video;
    test_restart;
    test_out_of_range;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
